// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU op codes and small helpers shared by the multiply/divide unit.
package mdu_pkg;
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;
  function automatic logic is_md(input logic [3:0] op);
    return op >= 4'(MDU_MULT) && op <= 4'(MDU_DIVU);
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == 4'(MDU_DIV) || op == 4'(MDU_DIVU);
  endfunction
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational full-width multiply and divide for the MDU.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);
  logic        w_sgn, w_na, w_nb, w_div;
  logic [63:0] w_prod;
  logic [31:0] w_a, w_b, w_d, w_q, w_r, w_sq, w_sr;
  assign w_sgn = op == 4'(MDU_MULT) || op == 4'(MDU_DIV);
  assign w_div = is_div(op);
  assign w_prod = {{32{w_sgn & rs[31]}}, rs} * {{32{w_sgn & rt[31]}}, rt};
  // Divide on magnitudes, then restore signs: quotient truncates toward zero, remainder follows the dividend.
  assign w_na = w_sgn & rs[31];
  assign w_nb = w_sgn & rt[31];
  assign w_a  = w_na ? -rs : rs;
  assign w_b  = w_nb ? -rt : rt;
  assign div_zero = w_div && rt == 32'd0;
  assign w_d  = w_b == 32'd0 ? 32'd1 : w_b;
  assign w_q  = w_a / w_d;
  assign w_r  = w_a % w_d;
  assign w_sq = (w_na ^ w_nb) ? -w_q : w_q;
  assign w_sr = w_na ? -w_r : w_r;
  assign res_hi = w_div ? w_sr : w_prod[63:32];
  assign res_lo = w_div ? w_sq : w_prod[31:0];
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit owning HI/LO; fixed-latency mult/div
// with the result held pending until the cycle counter expires.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_ans
);
  localparam int CW = $clog2(max_i(MULT_CYCLES, DIV_CYCLES) + 1);
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic          r_pend_skip;
  logic [31:0]   w_res_hi, w_res_lo;
  logic          w_div_zero, w_go;
  mdu_arith u_arith (
    .op       (mdu_op),
    .rs       (rs_data),
    .rt       (rt_data),
    .res_hi   (w_res_hi),
    .res_lo   (w_res_lo),
    .div_zero (w_div_zero)
  );
  assign w_go = start & ~busy;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_pend_hi   <= '0;
      r_pend_lo   <= '0;
      r_pend_skip <= 1'b0;
    end else begin
      if (w_go && is_md(mdu_op)) begin
        r_cnt       <= is_div(mdu_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        r_pend_hi   <= w_res_hi;
        r_pend_lo   <= w_res_lo;
        r_pend_skip <= w_div_zero;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Commit and move-to cannot coincide: commit only happens while busy.
      if (r_cnt == CW'(1) && !r_pend_skip) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_go && mdu_op == 4'(MDU_MTHI)) r_hi <= rs_data;
      if (w_go && mdu_op == 4'(MDU_MTLO)) r_lo <= rs_data;
    end
  end
  assign busy    = r_cnt != '0;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign mdu_ans = mdu_op == 4'(MDU_MFHI) ? r_hi : mdu_op == 4'(MDU_MFLO) ? r_lo : 32'd0;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: table-driven, directed and randomized checks of mdu_unit against a behavioural model.
module tb_mdu_unit;
  import mdu_pkg::*;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data, rt_data, hi, lo, mdu_ans;
  logic        busy;
  int          n_pass = 0, n_tot = 0;
  logic [31:0] m_hi, m_lo;
  always #5 clk = ~clk;
  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy),
    .hi(hi), .lo(lo), .mdu_ans(mdu_ans)
  );
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, eh, el;
    int          cyc;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int ncyc, output logic [31:0] mh, output logic [31:0] ml);
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE;
    mh = hi; ml = lo; ncyc = 0;
    while (busy && ncyc < 50) begin
      ncyc++;
      @(posedge clk); #1;
    end
  endtask
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cyc = 0;
    case (op)
      4'(MDU_MULT):  begin q = sa * sb; {m_hi, m_lo} = q; cyc = 5; end
      4'(MDU_MULTU): begin p = 64'(a) * 64'(b); {m_hi, m_lo} = p; cyc = 5; end
      4'(MDU_DIV): begin
        cyc = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      4'(MDU_DIVU): begin
        cyc = 10;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      4'(MDU_MTHI): m_hi = a;
      4'(MDU_MTLO): m_lo = a;
      default: ;
    endcase
  endtask
  initial begin
    int          nc, ec, nb;
    logic [31:0] mh, ml, ph, pl, a, b;
    logic [3:0]  op;
    logic [3:0]  ops[6] = '{4'(MDU_MULT), 4'(MDU_MULTU), 4'(MDU_DIV), 4'(MDU_DIVU), 4'(MDU_MTHI), 4'(MDU_MTLO)};
    tbl[0]  = '{4'(MDU_MULT),  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    tbl[1]  = '{4'(MDU_MULTU), 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 5};
    tbl[2]  = '{4'(MDU_DIVU),  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    tbl[3]  = '{4'(MDU_DIV),   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[4]  = '{4'(MDU_DIV),   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[5]  = '{4'(MDU_MTHI),  32'h00000011, 32'd0,        32'h00000011, 32'h80000000, 0};
    tbl[6]  = '{4'(MDU_MTLO),  32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    tbl[7]  = '{4'(MDU_DIV),   32'd1234,     32'd0,        32'h00000011, 32'h00000022, 10};
    tbl[8]  = '{4'(MDU_DIVU),  32'd99,       32'd0,        32'h00000011, 32'h00000022, 10};
    tbl[9]  = '{4'(MDU_MTHI),  32'h00001234, 32'd0,        32'h00001234, 32'h00000022, 0};
    tbl[10] = '{4'(MDU_MTLO),  32'h0000ABCD, 32'd0,        32'h00001234, 32'h0000ABCD, 0};
    tbl[11] = '{4'd9,          32'h00000005, 32'd6,        32'h00001234, 32'h0000ABCD, 0};
    tbl[12] = '{4'(MDU_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    reset = 1'b1; start = 1'b0; mdu_op = MDU_NONE; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    ph = 32'd0; pl = 32'd0;
    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, nc, mh, ml);
      chk($sformatf("vec%0d_cyc", i), 32'(nc), 32'(tbl[i].cyc));
      if (tbl[i].cyc > 0) begin
        chk($sformatf("vec%0d_mid_hi", i), mh, ph);
        chk($sformatf("vec%0d_mid_lo", i), ml, pl);
      end
      chk($sformatf("vec%0d_hi", i), hi, tbl[i].eh);
      chk($sformatf("vec%0d_lo", i), lo, tbl[i].el);
      @(negedge clk);
      start = 1'b1; mdu_op = MDU_MFHI; #1;
      chk($sformatf("vec%0d_mfhi", i), mdu_ans, tbl[i].eh);
      mdu_op = MDU_MFLO; #1;
      chk($sformatf("vec%0d_mflo", i), mdu_ans, tbl[i].el);
      start = 1'b0; mdu_op = MDU_NONE;
      ph = tbl[i].eh; pl = tbl[i].el;
    end
    m_hi = ph; m_lo = pl;
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = $urandom_range(0, 5) == 0 ? 32'd0 : ($urandom_range(0, 1) == 0 ? $urandom : $urandom_range(1, 100));
      ph = m_hi; pl = m_lo;
      ref_op(op, a, b, ec);
      do_op(op, a, b, nc, mh, ml);
      chk($sformatf("rnd%0d_cyc", i), 32'(nc), 32'(ec));
      if (ec > 0) chk($sformatf("rnd%0d_mid_hi", i), mh, ph);
      chk($sformatf("rnd%0d_hi", i), hi, m_hi);
      chk($sformatf("rnd%0d_lo", i), lo, m_lo);
    end
    ph = m_hi;
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; rs_data = 32'hFFFFFFF9; rt_data = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE;
    nb = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (c == 3) chk("ign_mthi_hi", hi, ph);
      start   = (c == 1 || c == 2);
      mdu_op  = c == 1 ? MDU_MTHI : c == 2 ? MDU_DIV : MDU_NONE;
      rs_data = 32'h99; rt_data = 32'd3;
    end
    start = 1'b0; mdu_op = MDU_NONE;
    chk("ign_busy_cyc", 32'(nb), 32'd5);
    chk("ign_hi", hi, 32'hFFFFFFFF);
    chk("ign_lo", lo, 32'hFFFFFFD6);
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_DIV; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(MDU_MULT, 32'd3, 32'd4, nc, mh, ml);
    chk("post_rst_cyc", 32'(nc), 32'd5);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd12);
    repeat (12) @(negedge clk);
    chk("post_rst_stable_lo", lo, 32'd12);
    chk("post_rst_idle", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
